riscv_alu_arb: RTL and testbench

- Two-requester round-robin arbiter/sequencer that time-shares one riscv_alu instance.
- Sits between the ALU and two clients, e.g. the integer pipe (port 0) and a multi-cycle helper unit (port 1).
- Accepts requests on valid/ready handshakes, registers operands and drives the ALU for one cycle.
- Captures result and zero flag, then returns them to the granted requester on a valid/ready response channel.

---
 rtl/riscv_alu_arb.sv | 206 ++++++++++++++++++++
 tb/tb_riscv_alu_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_arb.sv
// riscv_alu_arb: two-requester round-robin sequencer in front of one riscv_alu.
// Each accepted request is latched, run through the ALU for one cycle, and
// the registered result is handed back to the granted requester.
// Optional feature: define RISCV_ALU_ARB_ILLEGAL_CHK_EN to reject control codes
// above ALU_CTRL_MAX. Such requests skip the ALU and answer one cycle after
// accept with out=0, zero=1, err=1. When the macro is undefined, every code goes
// to the ALU unchanged and o_rsp_err is always 0.
module riscv_alu_arb #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ALU_CTRL_MAX = 9
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  // requester 0
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic [3:0]      i_req0_ctrl,
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  // requester 1
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  input  logic [3:0]      i_req1_ctrl,
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  // shared response payload
  output logic [XLEN-1:0] o_rsp_out,
  output logic            o_rsp_zero,
  output logic            o_rsp_err,
  // ALU side
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  input  logic [XLEN-1:0] i_alu_out,
  input  logic            i_alu_zero,
  // status
  output logic            o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CTRL_MAX_C = 4'(ALU_CTRL_MAX);
`ifdef RISCV_ALU_ARB_ILLEGAL_CHK_EN
  localparam logic ILL_CHK_EN_C = 1'b1;
`else
  localparam logic ILL_CHK_EN_C = 1'b0;
`endif

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [3:0]      op_ctrl_q, op_ctrl_d;
  logic [XLEN-1:0] rsp_out_q, rsp_out_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win_valid_s;
  logic            win_sel_s;
  logic [XLEN-1:0] win_a_s;
  logic [XLEN-1:0] win_b_s;
  logic [3:0]      win_ctrl_s;
  logic            illegal_s;
  logic            rsp_ready_s;

  // Pick the winning requester: prio breaks a tie, otherwise the lone valid port wins.
  always_comb begin
    win_valid_s = 1'b0;
    win_sel_s   = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      win_valid_s = 1'b1;
      win_sel_s   = prio_q;
    end else if (i_req0_valid) begin
      win_valid_s = 1'b1;
      win_sel_s   = 1'b0;
    end else if (i_req1_valid) begin
      win_valid_s = 1'b1;
      win_sel_s   = 1'b1;
    end else begin
      win_valid_s = 1'b0;
      win_sel_s   = 1'b0;
    end
  end

  // Route the winner's operands and classify its control code.
  always_comb begin
    win_a_s    = {XLEN{1'b0}};
    win_b_s    = {XLEN{1'b0}};
    win_ctrl_s = 4'd0;
    if (win_sel_s) begin
      win_a_s    = i_req1_a;
      win_b_s    = i_req1_b;
      win_ctrl_s = i_req1_ctrl;
    end else begin
      win_a_s    = i_req0_a;
      win_b_s    = i_req0_b;
      win_ctrl_s = i_req0_ctrl;
    end
    illegal_s   = ILL_CHK_EN_C & (win_ctrl_s > CTRL_MAX_C);
    rsp_ready_s = grant_q ? i_rsp1_ready : i_rsp0_ready;
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_ctrl_d  = op_ctrl_q;
    rsp_out_d  = rsp_out_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid_s) begin
          grant_d = win_sel_s;
          if (illegal_s) begin
            // Illegal code never reaches the ALU; answer immediately.
            rsp_out_d  = {XLEN{1'b0}};
            rsp_zero_d = 1'b1;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            op_a_d    = win_a_s;
            op_b_d    = win_b_s;
            op_ctrl_d = win_ctrl_s;
            state_d   = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_out_d  = i_alu_out;
        rsp_zero_d = i_alu_zero;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_s) begin
          // The requester that just lost this round gets priority next time.
          prio_d  = ~grant_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      op_a_q     <= {XLEN{1'b0}};
      op_b_q     <= {XLEN{1'b0}};
      op_ctrl_q  <= 4'd0;
      rsp_out_q  <= {XLEN{1'b0}};
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_ctrl_q  <= op_ctrl_d;
      rsp_out_q  <= rsp_out_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Request ready is combinational from valid in IDLE and is held off during reset.
  assign o_req0_ready = i_rstn & (state_q == ST_IDLE) & win_valid_s & ~win_sel_s;
  assign o_req1_ready = i_rstn & (state_q == ST_IDLE) & win_valid_s &  win_sel_s;

  assign o_rsp0_valid = (state_q == ST_RESP) & ~grant_q;
  assign o_rsp1_valid = (state_q == ST_RESP) &  grant_q;
  assign o_rsp_out    = rsp_out_q;
  assign o_rsp_zero   = rsp_zero_q;
  assign o_rsp_err    = rsp_err_q;

  // The ALU operands always come from the latched copies, so they change only when a request is accepted.
  assign o_alu_a      = op_a_q;
  assign o_alu_b      = op_b_q;
  assign o_alu_ctrl   = op_ctrl_q;

  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_alu_arb.sv
// Scoreboard bench for riscv_alu_arb with a behavioural ALU attached.
module tb_riscv_alu_arb;

  localparam int XLEN = 32;
`ifdef RISCV_ALU_ARB_ILLEGAL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic            i_req0_valid, i_req1_valid;
  logic            o_req0_ready, o_req1_ready;
  logic [XLEN-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [3:0]      i_req0_ctrl, i_req1_ctrl;
  logic            o_rsp0_valid, o_rsp1_valid;
  logic            i_rsp0_ready, i_rsp1_ready;
  logic [XLEN-1:0] o_rsp_out;
  logic            o_rsp_zero, o_rsp_err;
  logic [XLEN-1:0] o_alu_a, o_alu_b;
  logic [3:0]      o_alu_ctrl;
  logic [XLEN-1:0] i_alu_out;
  logic            i_alu_zero;
  logic            o_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  riscv_alu_arb #(.XLEN(XLEN), .ALU_CTRL_MAX(9)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_ctrl(i_req0_ctrl),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_ctrl(i_req1_ctrl),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp_out(o_rsp_out), .o_rsp_zero(o_rsp_zero), .o_rsp_err(o_rsp_err),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
    .i_alu_out(i_alu_out), .i_alu_zero(i_alu_zero),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    i_alu_out  = alu_ref(o_alu_a, o_alu_b, o_alu_ctrl);
    i_alu_zero = (i_alu_out == 32'd0);
  end

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] out;
    logic        zero;
    logic        err;
    logic [31:0] aa;
    logic [31:0] ab;
    logic [3:0]  ac;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic        model_prio = 1'b0;
  logic [31:0] model_alu_a = 32'd0;
  logic [31:0] model_alu_b = 32'd0;
  logic [3:0]  model_alu_ctrl = 4'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard push: expected response derived from the request at accept time.
  task automatic push(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    exp_t e;
    e.acc = cyc;
    if (CHK_EN && (c > 4'd9)) begin
      e.lat = 1; e.out = 32'd0; e.zero = 1'b1; e.err = 1'b1;
    end else begin
      e.lat = 2; e.out = alu_ref(a, b, c); e.zero = (e.out == 32'd0); e.err = 1'b0;
      model_alu_a = a; model_alu_b = b; model_alu_ctrl = c;
    end
    e.aa = model_alu_a; e.ab = model_alu_b; e.ac = model_alu_ctrl;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  logic prev_v0 = 1'b0, prev_v1 = 1'b0;
  logic [31:0] prev_out;
  logic prev_zero, prev_err;

  task automatic check_port(input int p);
    logic v, pv, rdy, have;
    exp_t e;
    v    = (p == 0) ? o_rsp0_valid : o_rsp1_valid;
    pv   = (p == 0) ? prev_v0 : prev_v1;
    rdy  = (p == 0) ? i_rsp0_ready : i_rsp1_ready;
    have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (v) begin
      chk($sformatf("rsp%0d_expected", p), {63'd0, have}, 64'd1);
      if (have) begin
        e = (p == 0) ? q0[0] : q1[0];
        if (!pv) chk($sformatf("rsp%0d_latency", p), 64'(cyc - e.acc), 64'(e.lat));
        else     chk($sformatf("rsp%0d_stable", p), {30'd0, o_rsp_out, o_rsp_zero, o_rsp_err},
                     {30'd0, prev_out, prev_zero, prev_err});
        if (rdy) begin
          chk($sformatf("rsp%0d_data", p), {30'd0, o_rsp_out, o_rsp_zero, o_rsp_err},
              {30'd0, e.out, e.zero, e.err});
          chk($sformatf("rsp%0d_alu_hold", p), {o_alu_a, o_alu_b} ^ {60'd0, o_alu_ctrl},
              {e.aa, e.ab} ^ {60'd0, e.ac});
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          model_prio = (p == 0) ? 1'b1 : 1'b0;
        end
      end
    end
  endtask

  // Monitor: checks busy, arbitration and responses; pushes expectations on accepts.
  always @(negedge i_clk) begin
    logic mbusy;
    logic [1:0] exp_rdy;
    if (!i_rstn) begin
      prev_v0 = 1'b0;
      prev_v1 = 1'b0;
    end else begin
      mbusy = (q0.size() != 0) || (q1.size() != 0);
      chk("busy", {63'd0, o_busy}, {63'd0, mbusy});
      if (i_req0_valid || i_req1_valid) begin
        if (mbusy) exp_rdy = 2'b00;
        else if (i_req0_valid && i_req1_valid) exp_rdy = model_prio ? 2'b10 : 2'b01;
        else exp_rdy = i_req1_valid ? 2'b10 : 2'b01;
        chk("req_ready", {62'd0, o_req1_ready, o_req0_ready}, {62'd0, exp_rdy});
      end else if (o_req0_ready || o_req1_ready) begin
        chk("ready_without_valid", {62'd0, o_req1_ready, o_req0_ready}, 64'd0);
      end
      if (o_rsp0_valid && o_rsp1_valid) chk("rsp_onehot", 64'd2, 64'd1);
      check_port(0);
      check_port(1);
      if (o_req0_ready && i_req0_valid) push(0, i_req0_a, i_req0_b, i_req0_ctrl);
      else if (o_req1_ready && i_req1_valid) push(1, i_req1_a, i_req1_b, i_req1_ctrl);
      prev_v0 = o_rsp0_valid; prev_v1 = o_rsp1_valid;
      prev_out = o_rsp_out; prev_zero = o_rsp_zero; prev_err = o_rsp_err;
    end
  end

  // Random response backpressure during the random phase.
  always @(posedge i_clk) begin
    if (rand_rdy) begin
      #1;
      i_rsp0_ready = ($urandom_range(0, 2) != 0);
      i_rsp1_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    if (p == 0) begin
      i_req0_valid = v; i_req0_a = a; i_req0_b = b; i_req0_ctrl = c;
    end else begin
      i_req1_valid = v; i_req1_a = a; i_req1_b = b; i_req1_ctrl = c;
    end
  endtask

  // Issue n requests on one port, keeping valid high until each is accepted.
  task automatic run_port(input int p, input int n, input bit rnd,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] xa, xb;
    logic [3:0]  xc;
    bit got;
    int g;
    @(posedge i_clk); #1;
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        xa = $urandom; xb = $urandom; xc = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) xb = xa;
      end else begin
        xa = a; xb = b; xc = c;
      end
      set_req(p, 1'b1, xa, xb, xc);
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge i_clk);
        got = (p == 0) ? o_req0_ready : o_req1_ready;
      end
      if (!got) chk($sformatf("req%0d_accept_timeout", p), 64'd0, 64'd1);
      @(posedge i_clk); #1;
      if (rnd) begin
        g = $urandom_range(0, 2);
        if (g != 0) begin
          set_req(p, 1'b0, $urandom, $urandom, 4'($urandom));
          repeat (g) @(posedge i_clk);
          #1;
        end
      end
    end
    set_req(p, 1'b0, $urandom, $urandom, 4'($urandom));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && w < 400) begin
      @(posedge i_clk);
      w++;
    end
    if (w >= 400) chk("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_zero, o_rsp_err,
               o_busy, o_alu_ctrl, 53'd0} | {11'd0, o_rsp_out | o_alu_a | o_alu_b, 21'd0}, 64'd0);
  endtask

  initial begin
    i_rstn = 1'b0;
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset_outputs");
    @(posedge i_clk); #2;
    i_rstn = 1'b1;

    // Single ADD 5 + 7 on port 0.
    run_port(0, 1, 1'b0, 32'h0000_0005, 32'h0000_0007, 4'd0);
    drain();

    // Reset while an ADD is in EXEC: nothing may come back for it.
    run_port(0, 1, 1'b0, 32'h0000_0005, 32'h0000_0007, 4'd0);
    #2;
    i_rstn = 1'b0;
    q0.delete(); q1.delete();
    model_prio = 1'b0; model_alu_a = 32'd0; model_alu_b = 32'd0; model_alu_ctrl = 4'd0;
    @(negedge i_clk);
    check_all_zero("reset_mid_exec");
    @(posedge i_clk); #2;
    i_rstn = 1'b1;
    repeat (4) @(posedge i_clk);
    run_port(1, 1, 1'b0, 32'h0000_0010, 32'h0000_0003, 4'd1);
    drain();

    // Continuous contention: SUB 9,9 on port 0 against OR 1,2 on port 1.
    fork
      run_port(0, 4, 1'b0, 32'd9, 32'd9, 4'd1);
      run_port(1, 4, 1'b0, 32'd1, 32'd2, 4'd3);
    join
    drain();

    // Backpressure on port 1 for five cycles while port 0 keeps requesting.
    i_rsp1_ready = 1'b0;
    fork
      run_port(1, 1, 1'b0, 32'h0000_0001, 32'h0000_0002, 4'd3);
      begin
        repeat (2) @(posedge i_clk);
        run_port(0, 1, 1'b0, 32'h0000_0004, 32'h0000_0004, 4'd4);
      end
      begin
        for (int w = 0; w < 50 && !o_rsp1_valid; w++) @(negedge i_clk);
        if (!o_rsp1_valid) chk("rsp1_valid_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge i_clk);
        #1;
        i_rsp1_ready = 1'b1;
      end
    join
    drain();

    // Control code 4'hF on port 0.
    run_port(0, 1, 1'b0, 32'h1234_5678, 32'h0000_0001, 4'hF);
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    fork
      run_port(0, 40, 1'b1, 32'd0, 32'd0, 4'd0);
      run_port(1, 40, 1'b1, 32'd0, 32'd0, 4'd0);
    join
    rand_rdy = 1'b0;
    @(posedge i_clk); #1;
    i_rsp0_ready = 1'b1;
    i_rsp1_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
